// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
//   Shared definitions for the PLL lock sequencer:
//     - seq_state_e : FSM state encoding (also driven out on STATE)
//     - clog2_w     : counter width helper, never returns less than 1
//     - params_legal: parameter legality check used at elaboration
// ---------------------------------------------------------------------------
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Bits needed to hold values 0..value-1, minimum 1.
  function automatic int clog2_w(input int value);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < value) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

  function automatic bit params_legal(input int n_ch, input int lock_filt,
                                      input int stagger, input int cnt_w);
    return (n_ch >= 32'sd1) && (n_ch <= 32'sd8) && (lock_filt >= 32'sd2) &&
           (stagger >= 32'sd1) && (cnt_w >= 32'sd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     clk : destination clock
//     rst : asynchronous active-high reset, clears both stages to 0
//     d   : asynchronous input
//     q   : synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next-state of the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//   Waits for a stable PLL lock, then releases N_CH reset channels one at a
//   time, STAGGER cycles apart. Loss of lock while releasing or running puts
//   every channel back into reset and is recorded in a sticky flag and a
//   saturating counter.
//   Ports:
//     CLK0      : clock, rising edge
//     RESET     : asynchronous active-high reset
//     LOCK_RAW  : raw lock indicator, asynchronous to CLK0
//     CH_EN     : per-channel enable
//     FORCE_RST : restart the whole sequence (not counted as a loss)
//     CLR_LOST  : clear LOCK_LOST and LOSS_CNT
//     RST_OUT   : per-channel active-high reset
//     READY     : high while in RUN
//     LOCK_LOST : sticky loss-of-lock flag
//     LOSS_CNT  : saturating lock-loss count
//     STATE     : current FSM state
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int N_CH      = 4,
  parameter int LOCK_FILT = 1024,
  parameter int STAGGER   = 16,
  parameter int CNT_W     = 8
) (
  input  logic              CLK0,
  input  logic              RESET,
  input  logic              LOCK_RAW,
  input  logic [N_CH-1:0]   CH_EN,
  input  logic              FORCE_RST,
  input  logic              CLR_LOST,
  output logic [N_CH-1:0]   RST_OUT,
  output logic              READY,
  output logic              LOCK_LOST,
  output logic [CNT_W-1:0]  LOSS_CNT,
  output logic [1:0]        STATE
);

  import pll_seq_pkg::*;

  if (!params_legal(N_CH, LOCK_FILT, STAGGER, CNT_W)) begin : g_illegal_params
    $fatal(1, "pll_lock_sequencer: illegal N_CH, LOCK_FILT, STAGGER or CNT_W");
  end

  localparam int FILT_W = clog2_w(LOCK_FILT);
  localparam int STAG_W = clog2_w(STAGGER);
  // Slot index runs one past the last channel to mark "all slots opened".
  localparam int SLOT_W = clog2_w(N_CH + 32'sd1);

  localparam logic [FILT_W-1:0] FILT_LAST   = FILT_W'(LOCK_FILT - 32'sd1);
  localparam logic [STAG_W-1:0] STAG_RELOAD = STAG_W'(STAGGER - 32'sd1);
  localparam logic [SLOT_W-1:0] SLOT_DONE   = SLOT_W'(N_CH);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);

  logic              lock_s;
  logic              loss_event;

  seq_state_e        state_q,     state_d;
  logic [FILT_W-1:0] filt_cnt_q,  filt_cnt_d;
  logic [STAG_W-1:0] stag_cnt_q,  stag_cnt_d;
  logic [SLOT_W-1:0] slot_q,      slot_d;
  logic [N_CH-1:0]   released_q,  released_d;
  logic [N_CH-1:0]   rst_out_q,   rst_out_d;
  logic              ready_q,     ready_d;
  logic              lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]  loss_cnt_q,  loss_cnt_d;

  sync_2ff u_lock_sync (
    .clk (CLK0),
    .rst (RESET),
    .d   (LOCK_RAW),
    .q   (lock_s)
  );

  // Sequencing FSM: lock filter, staggered slot release, loss/force handling.
  always_comb begin
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    stag_cnt_d = stag_cnt_q;
    slot_d     = slot_q;
    released_d = released_q;
    loss_event = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        released_d = '0;
        if (lock_s && !FORCE_RST) begin
          state_d    = FILTER;
          filt_cnt_d = '0;
        end else begin
          state_d    = WAIT_LOCK;
        end
      end

      FILTER: begin
        released_d = '0;
        if (!lock_s || FORCE_RST) begin
          state_d = WAIT_LOCK;
        end else if (filt_cnt_q == FILT_LAST) begin
          state_d    = RELEASE;
          slot_d     = '0;
          stag_cnt_d = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + FILT_W'(1'b1);
        end
      end

      RELEASE: begin
        if (!lock_s) begin
          loss_event = 1'b1;
          state_d    = WAIT_LOCK;
          released_d = '0;
        end else if (FORCE_RST) begin
          state_d    = WAIT_LOCK;
          released_d = '0;
        end else if (slot_q == SLOT_DONE) begin
          // Last slot opened on the previous cycle.
          state_d = RUN;
        end else if (stag_cnt_q == '0) begin
          // Slot opens; a disabled channel still uses up its slot.
          for (int i = 0; i < N_CH; i++) begin
            if (slot_q == SLOT_W'(i)) begin
              released_d[i] = 1'b1;
            end else begin
              released_d[i] = released_q[i];
            end
          end
          slot_d     = slot_q + SLOT_W'(1'b1);
          stag_cnt_d = STAG_RELOAD;
        end else begin
          stag_cnt_d = stag_cnt_q - STAG_W'(1'b1);
        end
      end

      RUN: begin
        if (!lock_s) begin
          loss_event = 1'b1;
          state_d    = WAIT_LOCK;
          released_d = '0;
        end else if (FORCE_RST) begin
          state_d    = WAIT_LOCK;
          released_d = '0;
        end else begin
          state_d    = RUN;
        end
      end

      default: begin
        state_d    = WAIT_LOCK;
        released_d = '0;
      end
    endcase
  end

  // Registered outputs and lock-loss bookkeeping.
  always_comb begin
    // CH_EN is sampled here, so enable changes show one cycle later.
    rst_out_d   = ~(released_d & CH_EN);
    ready_d     = (state_d == RUN);
    lock_lost_d = lock_lost_q;
    loss_cnt_d  = loss_cnt_q;

    if (loss_event) begin
      // A loss wins over a coincident clear: the new loss is the only one left.
      lock_lost_d = 1'b1;
      if (CLR_LOST) begin
        loss_cnt_d = CNT_ONE;
      end else if (loss_cnt_q != CNT_MAX) begin
        loss_cnt_d = loss_cnt_q + CNT_ONE;
      end else begin
        loss_cnt_d = loss_cnt_q;
      end
    end else if (CLR_LOST) begin
      lock_lost_d = 1'b0;
      loss_cnt_d  = '0;
    end else begin
      lock_lost_d = lock_lost_q;
      loss_cnt_d  = loss_cnt_q;
    end
  end

  // State and output registers; RESET drives every channel into reset at once.
  always_ff @(posedge CLK0 or posedge RESET) begin
    if (RESET) begin
      state_q     <= WAIT_LOCK;
      filt_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      slot_q      <= '0;
      released_q  <= '0;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      filt_cnt_q  <= filt_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      slot_q      <= slot_d;
      released_q  <= released_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign RST_OUT   = rst_out_q;
  assign READY     = ready_q;
  assign LOCK_LOST = lock_lost_q;
  assign LOSS_CNT  = loss_cnt_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed scenarios plus randomized stimulus for pll_lock_sequencer.
//   The reference model tracks a single timeline: the number of edges since
//   the sequence entered filtering. State, channel releases and READY are
//   all derived from that number with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int N_CH      = 4;
  localparam int LOCK_FILT = 8;
  localparam int STAGGER   = 4;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int READY_T   = LOCK_FILT + 2 + STAGGER * (N_CH - 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              lock_raw;
  logic [N_CH-1:0]   ch_en;
  logic              force_rst;
  logic              clr_lost;
  logic [N_CH-1:0]   rst_out;
  logic              ready;
  logic              lock_lost;
  logic [CNT_W-1:0]  loss_cnt;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;

  // reference model
  bit              m_s1;
  bit              m_s2;
  int              m_seq;   // -1 when not sequencing
  bit              m_lost;
  int              m_cnt;
  logic [N_CH-1:0] m_rst;

  int hold;

  pll_lock_sequencer #(
    .N_CH      (N_CH),
    .LOCK_FILT (LOCK_FILT),
    .STAGGER   (STAGGER),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK0      (clk),
    .RESET     (rst),
    .LOCK_RAW  (lock_raw),
    .CH_EN     (ch_en),
    .FORCE_RST (force_rst),
    .CLR_LOST  (clr_lost),
    .RST_OUT   (rst_out),
    .READY     (ready),
    .LOCK_LOST (lock_lost),
    .LOSS_CNT  (loss_cnt),
    .STATE     (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_seq  = -1;
    m_lost = 1'b0;
    m_cnt  = 0;
    m_rst  = '1;
  endtask

  task automatic model_edge();
    bit lk;
    bit loss;
    lk   = m_s2;
    m_s2 = m_s1;
    m_s1 = lock_raw;
    loss = 1'b0;
    if (m_seq < 0) begin
      if (lk && !force_rst) m_seq = 0;
    end else if (m_seq < LOCK_FILT) begin
      if (!lk || force_rst) m_seq = -1;
      else m_seq++;
    end else begin
      if (!lk) begin
        loss  = 1'b1;
        m_seq = -1;
      end else if (force_rst) begin
        m_seq = -1;
      end else if (m_seq < 1000000) begin
        m_seq++;
      end
    end
    if (loss) begin
      m_lost = 1'b1;
      m_cnt  = clr_lost ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
    end else if (clr_lost) begin
      m_lost = 1'b0;
      m_cnt  = 0;
    end
    for (int k = 0; k < N_CH; k++) begin
      m_rst[k] = !((m_seq >= LOCK_FILT + 1 + STAGGER * k) && ch_en[k]);
    end
  endtask

  function automatic int model_state();
    if (m_seq < 0) return 0;
    if (m_seq < LOCK_FILT) return 1;
    if (m_seq < READY_T) return 2;
    return 3;
  endfunction

  task automatic compare_all();
    check_val("rst_out",   int'(rst_out),   int'(m_rst));
    check_val("ready",     int'(ready),     (m_seq >= READY_T) ? 1 : 0);
    check_val("state",     int'(state),     model_state());
    check_val("lock_lost", int'(lock_lost), int'(m_lost));
    check_val("loss_cnt",  int'(loss_cnt),  m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_val("async_rst_out",   int'(rst_out),   'hf);
    check_val("async_ready",     int'(ready),     0);
    check_val("async_state",     int'(state),     0);
    check_val("async_lock_lost", int'(lock_lost), 0);
    check_val("async_loss_cnt",  int'(loss_cnt),  0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    lock_raw  = 1'b0;
    ch_en     = 4'b1111;
    force_rst = 1'b0;
    clr_lost  = 1'b0;
    hold      = 0;
    model_reset();

    // reset state
    #1;
    check_val("reset_rst_out", int'(rst_out), 'hf);
    check_val("reset_ready",   int'(ready),   0);
    check_val("reset_state",   int'(state),   0);
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_hold_rst_out",  int'(rst_out),  'hf);
    check_val("reset_hold_loss_cnt", int'(loss_cnt), 0);
    rst = 1'b0;
    repeat (3) step();

    // nominal release timeline from the first edge sampling LOCK_RAW=1
    lock_raw = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      step();
      if (n == 11) check_val("t11_rst0", int'(rst_out[0]), 1);
      if (n == 12) check_val("t12_rst0", int'(rst_out[0]), 0);
      if (n == 15) check_val("t15_rst1", int'(rst_out[1]), 1);
      if (n == 16) check_val("t16_rst1", int'(rst_out[1]), 0);
      if (n == 20) check_val("t20_rst2", int'(rst_out[2]), 0);
      if (n == 24) check_val("t24_rst3", int'(rst_out[3]), 0);
      if (n == 24) check_val("t24_ready", int'(ready), 0);
      if (n == 25) check_val("t25_ready", int'(ready), 1);
    end

    // repeated lock loss in RUN, counter saturates
    for (int r = 0; r < 4; r++) begin
      lock_raw = 1'b0;
      step();
      step();
      check_val("loss_ready_before", int'(ready), 1);
      step();
      check_val("loss_rst_out",   int'(rst_out),   'hf);
      check_val("loss_lock_lost", int'(lock_lost), 1);
      check_val("loss_cnt_sat",   int'(loss_cnt),  (r + 1 < 3) ? r + 1 : 3);
      lock_raw = 1'b1;
      repeat (26) step();
      check_val("loss_relock_ready", int'(ready), 1);
    end

    // clear coincident with a loss event
    lock_raw = 1'b0;
    step();
    step();
    clr_lost = 1'b1;
    step();
    clr_lost = 1'b0;
    check_val("clr_loss_lock_lost", int'(lock_lost), 1);
    check_val("clr_loss_cnt",       int'(loss_cnt),  1);
    clr_lost = 1'b1;
    step();
    clr_lost = 1'b0;
    check_val("clr_lock_lost", int'(lock_lost), 0);
    check_val("clr_cnt",       int'(loss_cnt),  0);
    lock_raw = 1'b1;
    repeat (26) step();

    // forced resequence with channel 2 disabled
    ch_en     = 4'b1011;
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    check_val("force_rst_out",  int'(rst_out),  'hf);
    check_val("force_ready",    int'(ready),    0);
    check_val("force_loss_cnt", int'(loss_cnt), 0);
    for (int m = 1; m <= 24; m++) begin
      step();
      if (m == 10) check_val("fr_m10", int'(rst_out), 'he);
      if (m == 14) check_val("fr_m14", int'(rst_out), 'hc);
      if (m == 18) check_val("fr_m18", int'(rst_out), 'hc);
      if (m == 22) check_val("fr_m22", int'(rst_out), 'h4);
      if (m == 22) check_val("fr_m22_ready", int'(ready), 0);
      if (m == 23) check_val("fr_m23_ready", int'(ready), 1);
    end
    ch_en = 4'b1111;
    step();
    check_val("chen_late", int'(rst_out), 'h0);

    // short lock glitch during FILTER restarts the full filter
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    step();
    step();
    lock_raw = 1'b0;
    step();
    step();
    lock_raw = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      step();
      if (n == 11) check_val("glitch_t11_rst0", int'(rst_out[0]), 1);
      if (n == 12) check_val("glitch_t12_rst0", int'(rst_out[0]), 0);
      if (n == 12) check_val("glitch_lock_lost", int'(lock_lost), 0);
    end

    // asynchronous reset in the middle of RELEASE
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    for (int m = 1; m <= 15; m++) step();
    async_reset();
    repeat (30) step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (hold <= 0) begin
        lock_raw = ~lock_raw;
        hold     = lock_raw ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 6));
      end
      hold--;
      force_rst = ($urandom_range(0, 79) == 0);
      clr_lost  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom);
      if ($urandom_range(0, 999) == 0) async_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter N_CH, default 4, number of sequenced reset channels (legal 1..8).
REQ-002 Parameter LOCK_FILT, default 1024, consecutive synchronized-lock cycles required before release (legal >= 2).
REQ-003 Parameter STAGGER, default 16, cycles between successive channel releases (legal >= 1).
REQ-004 Parameter CNT_W, default 8, width of the lock-loss event counter.
REQ-005 CLK0  in  1  single clock; all logic on its rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 LOCK_RAW  in  1  raw PLL/CCC lock indicator, asynchronous to CLK0.
REQ-008 CH_EN  in  N_CH  per-channel enable, synchronous.
REQ-009 FORCE_RST  in  1  synchronous request to re-run the full sequence.
REQ-010 CLR_LOST  in  1  synchronous clear for LOCK_LOST and LOSS_CNT.
REQ-011 RST_OUT  out  N_CH  per-channel active-high reset, registered.
REQ-012 READY  out  1  high only in state RUN, registered.
REQ-013 LOCK_LOST  out  1  sticky loss-of-lock flag.
REQ-014 LOSS_CNT  out  CNT_W  saturating count of lock losses.
REQ-015 STATE  out  2  current FSM state encoding.

Function
REQ-016 LOCK_RAW SHALL pass through a 2-flop synchronizer; lock_s is the synchronizer output.
REQ-017 FSM states SHALL be WAIT_LOCK=0, FILTER=1, RELEASE=2, RUN=3.
REQ-018 WAIT_LOCK: all RST_OUT=1; lock_s=1 -> FILTER with the filter counter cleared.
REQ-019 FILTER: counter increments each cycle lock_s=1; lock_s=0 -> WAIT_LOCK with no count/flag change; counter reaching LOCK_FILT-1 -> RELEASE.
REQ-020 RELEASE: slot index k=0..N_CH-1; slot k opens STAGGER*k cycles after RELEASE entry and marks channel k released; after slot N_CH-1 opens -> RUN on the next cycle.
REQ-021 Disabled channels SHALL still consume their slot.
REQ-022 RST_OUT[i] SHALL be registered as NOT(released[i] AND CH_EN[i]), so CH_EN changes take effect 1 cycle later in RELEASE/RUN.
REQ-023 Timing: RST_OUT[0] SHALL fall exactly LOCK_FILT+4 rising edges after the first edge that samples LOCK_RAW=1 (CH_EN[0]=1, lock held).
REQ-024 lock_s falling in RELEASE or RUN SHALL clear all released bits, assert all RST_OUT and drop READY on the next edge, go to WAIT_LOCK, set LOCK_LOST and increment LOSS_CNT.
REQ-025 LOSS_CNT SHALL saturate at 2^CNT_W-1, never wrap.
REQ-026 FORCE_RST=1 in FILTER/RELEASE/RUN SHALL go to WAIT_LOCK and assert all RST_OUT without touching LOCK_LOST/LOSS_CNT; in WAIT_LOCK it holds the state.
REQ-027 Simultaneous lock loss and FORCE_RST SHALL be treated as a lock loss (flag set, count incremented).
REQ-028 CLR_LOST SHALL clear LOCK_LOST and LOSS_CNT; coincident with a loss event the result SHALL be LOCK_LOST=1, LOSS_CNT=1.

Reset
REQ-029 RESET SHALL asynchronously force: state WAIT_LOCK, synchronizer flops 0, counters 0, released bits 0, RST_OUT all 1, READY 0, LOCK_LOST 0, LOSS_CNT 0, STATE 0.
REQ-030 RESET asserted mid-RELEASE or mid-RUN SHALL assert every RST_OUT immediately (not on a clock edge).

Structure
REQ-031 State encodings, the clog2 width helper and parameter-legality checks SHALL live in shared package pll_seq_pkg.
REQ-032 The 2-flop synchronizer SHALL be a separate sub-module sync_2ff (async active-high reset to 0).
REQ-033 Elaboration SHALL fail for illegal N_CH, LOCK_FILT or STAGGER values.

Verification (N_CH=4, LOCK_FILT=8, STAGGER=4, CNT_W=2, CH_EN=4'b1111 unless stated)
REQ-034 LOCK_RAW rises, held -> RST_OUT[0] falls at edge 12, [1] at 16, [2] at 20, [3] at 24, READY=1 at edge 25.
REQ-035 LOCK_RAW glitches low for 2 cycles during FILTER -> back to WAIT_LOCK, LOCK_LOST=0, release restarts full LOCK_FILT count.
REQ-036 LOCK_RAW drops in RUN, 4 times -> RST_OUT=4'b1111 3 cycles after drop, LOCK_LOST=1, LOSS_CNT=1,2,3,3 (saturated).
REQ-037 CH_EN=4'b1011 -> RST_OUT[2] stays 1, others release on schedule; CH_EN[2] set in RUN -> RST_OUT[2]=0 one cycle later.
REQ-038 FORCE_RST pulse in RUN -> all RST_OUT=1, READY=0, LOSS_CNT unchanged, resequence completes with REQ-034 relative timing.
REQ-039 RESET asserted mid-RELEASE -> RST_OUT=4'b1111 without a clock edge; CLR_LOST coincident with loss -> LOCK_LOST=1, LOSS_CNT=1.
